// File: rtl/mouse_bounds_sequencer.sv
// mouse_bounds_sequencer
//   Programs the mouse controller's cursor window for one of NUM_MODES screen
//   regions. A request selects a bound set; the block then issues four strobed
//   writes (max_x, max_y, min_x, min_y) on a shared value bus. The max bounds
//   can optionally be reduced by the cursor size, saturating at the matching
//   min bound. One request can be held pending while a sequence is running.
//
// Ports
//   clk          in   1        clock
//   rst          in   1        synchronous reset, active-high
//   req          in   1        request pulse, sampled every cycle
//   req_mode     in   MODE_W   bound set to program, valid with req
//   cursor_comp  in   1        1: subtract cursor size from max bounds
//   value        out  VALUE_W  bound value, 0 when no strobe is high
//   setmax_x     out  1        one-cycle write strobe
//   setmax_y     out  1        one-cycle write strobe
//   setmin_x     out  1        one-cycle write strobe
//   setmin_y     out  1        one-cycle write strobe
//   busy         out  1        sequence in progress
//   done         out  1        one-cycle pulse after the final strobe
//   active_mode  out  MODE_W   mode of the last started sequence
//   err          out  1        one-cycle pulse for a request with an unknown mode
module mouse_bounds_sequencer #(
  parameter int VALUE_W    = 12,
  parameter int NUM_MODES  = 4,
  parameter int CURSOR_W   = 16,
  parameter int CURSOR_H   = 16,
  parameter int GAP_CYCLES = 0,
  // Per mode, LSB-first fields: max_x, max_y, min_x, min_y.
  parameter logic [NUM_MODES*4*VALUE_W-1:0] MODE_BOUNDS = {
    VALUE_W'(12'd0),   VALUE_W'(12'd0),   VALUE_W'(12'd763), VALUE_W'(12'd1019),
    VALUE_W'(12'd0),   VALUE_W'(12'd0),   VALUE_W'(12'd763), VALUE_W'(12'd1019),
    VALUE_W'(12'd367), VALUE_W'(12'd361), VALUE_W'(12'd667), VALUE_W'(12'd661),
    VALUE_W'(12'd0),   VALUE_W'(12'd0),   VALUE_W'(12'd763), VALUE_W'(12'd1019)
  },
  localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [MODE_W-1:0]  req_mode,
  input  logic               cursor_comp,
  output logic [VALUE_W-1:0] value,
  output logic               setmax_x,
  output logic               setmax_y,
  output logic               setmin_x,
  output logic               setmin_y,
  output logic               busy,
  output logic               done,
  output logic [MODE_W-1:0]  active_mode,
  output logic               err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [VALUE_W:0] CUR_W_EXT = (VALUE_W+1)'(CURSOR_W);
  localparam logic [VALUE_W:0] CUR_H_EXT = (VALUE_W+1)'(CURSOR_H);
  // Gap counter reload value; only meaningful when GAP_CYCLES > 0.
  localparam logic [3:0]       GAP_LAST  = 4'(GAP_CYCLES - 1);

  // Field f (0=max_x,1=max_y,2=min_x,3=min_y) of bound set m.
  function automatic logic [VALUE_W-1:0] bound_field(input logic [MODE_W-1:0] m,
                                                     input logic [1:0]        f);
    int base;
    base = (int'(m) * 4 + int'(f)) * VALUE_W;
    return MODE_BOUNDS[base +: VALUE_W];
  endfunction

  // max - sub computed one bit wider so underflow is visible; clamps to min.
  function automatic logic [VALUE_W-1:0] comp_max(input logic [VALUE_W-1:0] max_v,
                                                  input logic [VALUE_W-1:0] min_v,
                                                  input logic [VALUE_W:0]   sub);
    logic [VALUE_W:0] diff;
    diff = {1'b0, max_v} - sub;
    if (({1'b0, max_v} < sub) || (diff[VALUE_W-1:0] < min_v)) begin
      return min_v;
    end else begin
      return diff[VALUE_W-1:0];
    end
  endfunction

  // Full four-field write set for a mode, LSB-first in strobe order.
  function automatic logic [4*VALUE_W-1:0] calc_bounds(input logic [MODE_W-1:0] m,
                                                       input logic              comp);
    logic [VALUE_W-1:0] mx_x, mx_y, mn_x, mn_y;
    mx_x = bound_field(m, 2'd0);
    mx_y = bound_field(m, 2'd1);
    mn_x = bound_field(m, 2'd2);
    mn_y = bound_field(m, 2'd3);
    if (comp) begin
      mx_x = comp_max(mx_x, mn_x, CUR_W_EXT);
      mx_y = comp_max(mx_y, mn_y, CUR_H_EXT);
    end else begin
      mx_x = mx_x;
      mx_y = mx_y;
    end
    return {mn_y, mn_x, mx_y, mx_x};
  endfunction

  state_t               state_r;
  logic [1:0]           idx_r;
  logic [3:0]           gap_cnt_r;
  logic [4*VALUE_W-1:0] bounds_r;
  logic                 pend_valid_r;
  logic [MODE_W-1:0]    pend_mode_r;
  logic                 pend_comp_r;

  logic                 req_legal_s;
  logic                 req_illegal_s;
  logic [MODE_W-1:0]    launch_mode_s;
  logic                 launch_comp_s;
  logic [4*VALUE_W-1:0] launch_bounds_s;
  logic [1:0]           next_idx_s;
  logic [VALUE_W-1:0]   next_value_s;

  // Request classification and the bound set a launch would use this cycle.
  always_comb begin
    req_legal_s   = 1'b0;
    req_illegal_s = 1'b0;
    if (req) begin
      if (int'(req_mode) < NUM_MODES) begin
        req_legal_s = 1'b1;
      end else begin
        req_illegal_s = 1'b1;
      end
    end else begin
      req_legal_s   = 1'b0;
      req_illegal_s = 1'b0;
    end

    // A fresh request takes priority over a stored one.
    if (req_legal_s) begin
      launch_mode_s = req_mode;
      launch_comp_s = cursor_comp;
    end else begin
      launch_mode_s = pend_mode_r;
      launch_comp_s = pend_comp_r;
    end
    launch_bounds_s = calc_bounds(launch_mode_s, launch_comp_s);

    next_idx_s   = idx_r + 2'd1;
    next_value_s = bounds_r[int'(next_idx_s) * VALUE_W +: VALUE_W];
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= 2'd0;
      gap_cnt_r    <= 4'd0;
      bounds_r     <= '0;
      pend_valid_r <= 1'b0;
      pend_mode_r  <= '0;
      pend_comp_r  <= 1'b0;
      value        <= '0;
      setmax_x     <= 1'b0;
      setmax_y     <= 1'b0;
      setmin_x     <= 1'b0;
      setmin_y     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      active_mode  <= '0;
      err          <= 1'b0;
    end else begin
      // Strobes, value and pulses default low; states below raise them.
      value    <= '0;
      setmax_x <= 1'b0;
      setmax_y <= 1'b0;
      setmin_x <= 1'b0;
      setmin_y <= 1'b0;
      done     <= 1'b0;
      err      <= req_illegal_s;

      case (state_r)
        ST_IDLE, ST_DONE: begin
          // pend_valid_r can only be set here when coming from ST_DONE.
          if (req_legal_s || pend_valid_r) begin
            state_r      <= ST_WRITE;
            idx_r        <= 2'd0;
            bounds_r     <= launch_bounds_s;
            active_mode  <= launch_mode_s;
            pend_valid_r <= 1'b0;
            busy         <= 1'b1;
            setmax_x     <= 1'b1;
            value        <= launch_bounds_s[VALUE_W-1:0];
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end

        ST_WRITE: begin
          if (req_legal_s) begin
            pend_valid_r <= 1'b1;
            pend_mode_r  <= req_mode;
            pend_comp_r  <= cursor_comp;
          end else begin
            pend_valid_r <= pend_valid_r;
          end

          if (idx_r == 2'd3) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (GAP_CYCLES == 0) begin
            idx_r    <= next_idx_s;
            value    <= next_value_s;
            setmax_y <= (next_idx_s == 2'd1);
            setmin_x <= (next_idx_s == 2'd2);
            setmin_y <= (next_idx_s == 2'd3);
          end else begin
            state_r   <= ST_GAP;
            gap_cnt_r <= GAP_LAST;
          end
        end

        ST_GAP: begin
          if (req_legal_s) begin
            pend_valid_r <= 1'b1;
            pend_mode_r  <= req_mode;
            pend_comp_r  <= cursor_comp;
          end else begin
            pend_valid_r <= pend_valid_r;
          end

          if (gap_cnt_r == 4'd0) begin
            state_r  <= ST_WRITE;
            idx_r    <= next_idx_s;
            value    <= next_value_s;
            setmax_y <= (next_idx_s == 2'd1);
            setmin_x <= (next_idx_s == 2'd2);
            setmin_y <= (next_idx_s == 2'd3);
          end else begin
            gap_cnt_r <= gap_cnt_r - 4'd1;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
